// File: rtl/regfile_pkg.sv
// Shared sizing and the write-request record for the regfile writeback path.
package regfile_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
    localparam int ZERO_REG   = 0;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/wr_req_fifo.sv
// Small write-request FIFO with asynchronous clear and per-entry taps so the
// owner can see every queued destination register, not just the head.
module wr_req_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 2
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_push,
    input  logic [ADDR_WIDTH-1:0]              i_push_addr,
    input  logic [DATA_WIDTH-1:0]              i_push_data,
    input  logic                               i_pop,
    output logic                               o_full,
    output logic                               o_empty,
    output logic [ADDR_WIDTH-1:0]              o_head_addr,
    output logic [DATA_WIDTH-1:0]              o_head_data,
    output logic [DEPTH-1:0]                   o_entry_valid,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0]   o_entry_addr
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][ADDR_WIDTH-1:0] r_addr;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_data;
    logic [DEPTH-1:0]                 r_valid;
    logic [DEPTH-1:0]                 w_valid_next;
    logic [PW-1:0]                    r_wr_ptr;
    logic [PW-1:0]                    r_rd_ptr;
    logic                             w_push;
    logic                             w_pop;

    // Entries fill contiguously, so full/empty fall straight out of the valid bits.
    assign o_full        = &r_valid;
    assign o_empty       = ~|r_valid;
    assign w_push        = i_push && !o_full;
    assign w_pop         = i_pop && !o_empty;
    assign o_head_addr   = r_addr[r_rd_ptr];
    assign o_head_data   = r_data[r_rd_ptr];
    assign o_entry_valid = r_valid;
    assign o_entry_addr  = r_addr;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        assign w_valid_next[gi] = (r_valid[gi] && !(w_pop && (r_rd_ptr == PW'(gi))))
                                || (w_push && (r_wr_ptr == PW'(gi)));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_valid <= w_valid_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= i_push_addr;
            r_data[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the regfile write port between two queued writeback
// requesters, with a per-register pending vector for hazard detection.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       Reset,
    input  logic                       ReqValid0,
    output logic                       ReqReady0,
    input  logic [ADDR_WIDTH-1:0]      ReqAddr0,
    input  logic [DATA_WIDTH-1:0]      ReqData0,
    input  logic                       ReqValid1,
    output logic                       ReqReady1,
    input  logic [ADDR_WIDTH-1:0]      ReqAddr1,
    input  logic [DATA_WIDTH-1:0]      ReqData1,
    output logic                       RegWrite,
    output logic [ADDR_WIDTH-1:0]      WriteAddr,
    output logic [DATA_WIDTH-1:0]      WriteData,
    output logic [(2**ADDR_WIDTH)-1:0] Pending,
    output logic                       Idle
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [1:0]                                  w_req_valid;
    logic [1:0][ADDR_WIDTH-1:0]                  w_req_addr;
    logic [1:0][DATA_WIDTH-1:0]                  w_req_data;
    logic [1:0]                                  w_ready;
    logic [1:0]                                  w_push;
    logic [1:0]                                  w_full;
    logic [1:0]                                  w_empty;
    logic [1:0][ADDR_WIDTH-1:0]                  w_head_addr;
    logic [1:0][DATA_WIDTH-1:0]                  w_head_data;
    logic [1:0][FIFO_DEPTH-1:0]                  w_entry_valid;
    logic [1:0][FIFO_DEPTH-1:0][ADDR_WIDTH-1:0]  w_entry_addr;
    logic [1:0]                                  w_grant;
    logic [NREGS-1:0]                            w_pending;

    logic                  r_reg_write;
    logic [ADDR_WIDTH-1:0] r_write_addr;
    logic [DATA_WIDTH-1:0] r_write_data;
    logic                  r_last_grant;

    assign w_req_valid = {ReqValid1, ReqValid0};
    assign w_req_addr  = {ReqAddr1, ReqAddr0};
    assign w_req_data  = {ReqData1, ReqData0};
    assign ReqReady0   = w_ready[0];
    assign ReqReady1   = w_ready[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign w_ready[gi] = !w_full[gi] && !Reset;
        // Writes to the hardwired zero register are accepted but never queued.
        assign w_push[gi]  = w_req_valid[gi] && w_ready[gi]
                          && (w_req_addr[gi] != ADDR_WIDTH'(regfile_pkg::ZERO_REG));

        wr_req_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (FIFO_DEPTH)
        ) u_fifo (
            .i_clk         (clock),
            .i_rst         (Reset),
            .i_push        (w_push[gi]),
            .i_push_addr   (w_req_addr[gi]),
            .i_push_data   (w_req_data[gi]),
            .i_pop         (w_grant[gi]),
            .o_full        (w_full[gi]),
            .o_empty       (w_empty[gi]),
            .o_head_addr   (w_head_addr[gi]),
            .o_head_data   (w_head_data[gi]),
            .o_entry_valid (w_entry_valid[gi]),
            .o_entry_addr  (w_entry_addr[gi])
        );
    end

    // When both heads are waiting, the requester not served last time wins.
    assign w_grant[1] = !w_empty[1] && (w_empty[0] || !r_last_grant);
    assign w_grant[0] = !w_empty[0] && !w_grant[1];

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            r_reg_write  <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_last_grant <= 1'b1;
        end else begin
            r_reg_write <= |w_grant;
            if (w_grant[0]) begin
                r_write_addr <= w_head_addr[0];
                r_write_data <= w_head_data[0];
                r_last_grant <= 1'b0;
            end else if (w_grant[1]) begin
                r_write_addr <= w_head_addr[1];
                r_write_data <= w_head_data[1];
                r_last_grant <= 1'b1;
            end
        end
    end

    always_comb begin
        w_pending = '0;
        for (int q = 0; q < 2; q++) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                if (w_entry_valid[q][e]) w_pending[w_entry_addr[q][e]] = 1'b1;
            end
        end
        if (r_reg_write) w_pending[r_write_addr] = 1'b1;
    end

    assign RegWrite  = r_reg_write;
    assign WriteAddr = r_write_addr;
    assign WriteData = r_write_data;
    assign Pending   = w_pending;
    assign Idle      = w_empty[0] && w_empty[1] && !r_reg_write;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, latency, arbitration order,
// back-pressure, zero-register discard and reset while writes are in flight.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic                  clock = 1'b0;
    logic                  Reset;
    logic                  ReqValid0, ReqValid1;
    logic                  ReqReady0, ReqReady1;
    logic [ADDR_WIDTH-1:0] ReqAddr0, ReqAddr1;
    logic [DATA_WIDTH-1:0] ReqData0, ReqData1;
    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] WriteAddr;
    logic [DATA_WIDTH-1:0] WriteData;
    logic [NUM_REGS-1:0]   Pending;
    logic                  Idle;

    int total = 0;
    int bad   = 0;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    wr_req_t               mon_q [$];
    bit                    mon_en = 1'b0;

    regfile_write_arbiter #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FIFO_DEPTH (2)
    ) dut (
        .clock     (clock),
        .Reset     (Reset),
        .ReqValid0 (ReqValid0),
        .ReqReady0 (ReqReady0),
        .ReqAddr0  (ReqAddr0),
        .ReqData0  (ReqData0),
        .ReqValid1 (ReqValid1),
        .ReqReady1 (ReqReady1),
        .ReqAddr1  (ReqAddr1),
        .ReqData1  (ReqData1),
        .RegWrite  (RegWrite),
        .WriteAddr (WriteAddr),
        .WriteData (WriteData),
        .Pending   (Pending),
        .Idle      (Idle)
    );

    always #5 clock = ~clock;

    // Stand-in register file: commits on the edge after RegWrite is seen.
    always @(posedge clock) begin
        if (RegWrite) regs[WriteAddr] <= WriteData;
    end

    always @(negedge clock) begin
        if (mon_en && RegWrite) begin
            mon_q.push_back({WriteAddr, WriteData});
            $display("write addr=%0d data=%h", WriteAddr, WriteData);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        Reset = 1'b1;
        ReqValid0 = 1'b0; ReqAddr0 = '0; ReqData0 = '0;
        ReqValid1 = 1'b0; ReqAddr1 = '0; ReqData1 = '0;
        @(negedge clock);
        @(negedge clock);
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL rst_regwrite: got %b want 0", RegWrite); end
        total++; if (WriteAddr !== '0) begin bad++; $display("FAIL rst_addr: got %h want 0", WriteAddr); end
        total++; if (WriteData !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", WriteData); end
        total++; if (Pending !== '0) begin bad++; $display("FAIL rst_pending: got %h want 0", Pending); end
        total++; if (ReqReady0 !== 1'b0 || ReqReady1 !== 1'b0) begin
            bad++; $display("FAIL rst_ready: got %b%b want 00", ReqReady1, ReqReady0);
        end
        Reset = 1'b0;
        @(negedge clock);
        total++; if (ReqReady0 !== 1'b1 || ReqReady1 !== 1'b1) begin
            bad++; $display("FAIL rel_ready: got %b%b want 11", ReqReady1, ReqReady0);
        end
        total++; if (Idle !== 1'b1) begin bad++; $display("FAIL rel_idle: got %b want 1", Idle); end
        total++; if (Pending !== '0) begin bad++; $display("FAIL rel_pending: got %h want 0", Pending); end
        $display("reset checked");
    endtask

    task automatic test_single_write();
        ReqValid0 = 1'b1; ReqAddr0 = 5'd1; ReqData0 = 32'hDEADBEEF;
        @(posedge clock); #1;
        ReqValid0 = 1'b0;
        total++; if (Pending[1] !== 1'b1 || RegWrite !== 1'b0) begin
            bad++; $display("FAIL single_queued: got pend=%b rw=%b want pend=1 rw=0", Pending[1], RegWrite);
        end
        @(posedge clock); #1;
        total++; if ({RegWrite, WriteAddr, WriteData} !== {1'b1, 5'd1, 32'hDEADBEEF}) begin
            bad++; $display("FAIL single_port: got rw=%b a=%0d d=%h want rw=1 a=1 d=deadbeef", RegWrite, WriteAddr, WriteData);
        end
        total++; if (Pending[1] !== 1'b1) begin bad++; $display("FAIL single_pend_port: got %b want 1", Pending[1]); end
        @(posedge clock); #1;
        total++; if (RegWrite !== 1'b0 || Pending !== '0) begin
            bad++; $display("FAIL single_done: got rw=%b pend=%h want rw=0 pend=0", RegWrite, Pending);
        end
        total++; if (regs[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_regfile: got %h want deadbeef", regs[1]); end
        @(negedge clock);
        $display("single write addr=1 data=deadbeef");
    endtask

    task automatic test_arbitration();
        logic [ADDR_WIDTH-1:0] exp_addr [4];
        logic [DATA_WIDTH-1:0] exp_data [4];
        exp_addr = '{5'd2, 5'd3, 5'd4, 5'd5};
        exp_data = '{32'hCAFEBABE, 32'h12345678, 32'h0000AAAA, 32'h0000BBBB};
        Reset = 1'b1;
        @(negedge clock);
        Reset = 1'b0;
        ReqValid0 = 1'b1; ReqAddr0 = 5'd2; ReqData0 = 32'hCAFEBABE;
        ReqValid1 = 1'b1; ReqAddr1 = 5'd3; ReqData1 = 32'h12345678;
        @(negedge clock);
        ReqAddr0 = 5'd4; ReqData0 = 32'h0000AAAA;
        ReqAddr1 = 5'd5; ReqData1 = 32'h0000BBBB;
        @(negedge clock);
        ReqValid0 = 1'b0; ReqValid1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({RegWrite, WriteAddr, WriteData} !== {1'b1, exp_addr[k], exp_data[k]}) begin
                bad++;
                $display("FAIL arb_seq%0d: got rw=%b a=%0d d=%h want rw=1 a=%0d d=%h",
                         k, RegWrite, WriteAddr, WriteData, exp_addr[k], exp_data[k]);
            end
            $display("arb write %0d addr=%0d", k, WriteAddr);
            @(negedge clock);
        end
        total++; if (RegWrite !== 1'b0 || Idle !== 1'b1) begin
            bad++; $display("FAIL arb_drain: got rw=%b idle=%b want rw=0 idle=1", RegWrite, Idle);
        end
    endtask

    task automatic test_back_to_back();
        int idx0 = 0;
        int idx1 = 0;
        int first_block = -1;
        bit f0, f1;
        wr_req_t got0 [$];
        wr_req_t got1 [$];
        wr_req_t exp_req;
        mon_q.delete();
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 200 && (idx0 < 8 || idx1 < 8); cyc++) begin
            ReqValid0 = (idx0 < 8); ReqAddr0 = 5'(idx0 + 1);  ReqData0 = 32'hA0000000 + 32'(idx0);
            ReqValid1 = (idx1 < 8); ReqAddr1 = 5'(idx1 + 17); ReqData1 = 32'hB0000000 + 32'(idx1);
            if (first_block < 0 && (!ReqReady0 || !ReqReady1)) first_block = cyc;
            f0 = ReqValid0 && ReqReady0;
            f1 = ReqValid1 && ReqReady1;
            @(posedge clock);
            if (f0) idx0++;
            if (f1) idx1++;
            @(negedge clock);
        end
        ReqValid0 = 1'b0; ReqValid1 = 1'b0;
        for (int k = 0; k < 40 && !Idle; k++) @(negedge clock);
        mon_en = 1'b0;
        total++; if (Idle !== 1'b1) begin bad++; $display("FAIL b2b_drain: got idle=%b want 1", Idle); end
        total++; if (idx0 != 8 || idx1 != 8) begin
            bad++; $display("FAIL b2b_sent: got %0d/%0d want 8/8", idx0, idx1);
        end
        total++; if (first_block < 0 || first_block > 3) begin
            bad++; $display("FAIL b2b_backpressure: got first ready-low cycle %0d want 0..3", first_block);
        end
        total++; if (mon_q.size() != 16) begin
            bad++; $display("FAIL b2b_count: got %0d want 16", mon_q.size());
        end
        foreach (mon_q[i]) begin
            if (mon_q[i].data[31:28] == 4'hA) got0.push_back(mon_q[i]);
            else got1.push_back(mon_q[i]);
        end
        total++; if (got0.size() != 8 || got1.size() != 8) begin
            bad++; $display("FAIL b2b_split: got %0d/%0d want 8/8", got0.size(), got1.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (i < got0.size()) begin
                exp_req = {5'(i + 1), 32'hA0000000 + 32'(i)};
                total++; if (got0[i] !== exp_req) begin
                    bad++; $display("FAIL b2b_req0_%0d: got %h want %h", i, got0[i], exp_req);
                end
            end
            if (i < got1.size()) begin
                exp_req = {5'(i + 17), 32'hB0000000 + 32'(i)};
                total++; if (got1[i] !== exp_req) begin
                    bad++; $display("FAIL b2b_req1_%0d: got %h want %h", i, got1[i], exp_req);
                end
            end
        end
    endtask

    task automatic test_addr_zero();
        ReqValid0 = 1'b1; ReqAddr0 = 5'd0; ReqData0 = 32'hFFFFFFFF;
        total++; if (ReqReady0 !== 1'b1) begin bad++; $display("FAIL zero_ready: got %b want 1", ReqReady0); end
        @(posedge clock); #1;
        ReqValid0 = 1'b0;
        total++; if (Pending !== '0 || Idle !== 1'b1) begin
            bad++; $display("FAIL zero_queued: got pend=%h idle=%b want pend=0 idle=1", Pending, Idle);
        end
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            total++; if (RegWrite !== 1'b0 || Pending[0] !== 1'b0 || Idle !== 1'b1) begin
                bad++; $display("FAIL zero_port%0d: got rw=%b p0=%b idle=%b want 0 0 1", k, RegWrite, Pending[0], Idle);
            end
            @(negedge clock);
        end
        $display("zero-register write discarded");
    endtask

    task automatic test_reset_midflight();
        ReqValid0 = 1'b1; ReqAddr0 = 5'd7; ReqData0 = 32'h77777777;
        ReqValid1 = 1'b1; ReqAddr1 = 5'd9; ReqData1 = 32'h99999999;
        @(negedge clock);
        ReqAddr0 = 5'd8; ReqData0 = 32'h88888888; ReqValid1 = 1'b0;
        @(negedge clock);
        ReqValid0 = 1'b0;
        total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL mid_busy: got rw=%b want 1", RegWrite); end
        total++; if (Pending !== 32'h00000380) begin
            bad++; $display("FAIL mid_pending: got %h want 00000380", Pending);
        end
        #2 Reset = 1'b1;
        #1;
        total++; if (RegWrite !== 1'b0 || Pending !== '0) begin
            bad++; $display("FAIL mid_async: got rw=%b pend=%h want rw=0 pend=0", RegWrite, Pending);
        end
        total++; if (ReqReady0 !== 1'b0 || ReqReady1 !== 1'b0) begin
            bad++; $display("FAIL mid_ready: got %b%b want 00", ReqReady1, ReqReady0);
        end
        @(negedge clock);
        Reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            total++; if (RegWrite !== 1'b0 || Idle !== 1'b1) begin
                bad++; $display("FAIL mid_quiet%0d: got rw=%b idle=%b want 0 1", k, RegWrite, Idle);
            end
        end
        $display("reset mid-flight dropped queued writes");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_arbitration();
        test_back_to_back();
        test_addr_zero();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
